// File: rtl/ysyx_25020037_clint_mh.sv
// rtl/ysyx_25020037_clint_mh.sv - multi-hart CLINT on AXI4-Lite; msip registers built only when CLINT_MSIP_EN is defined
module ysyx_25020037_clint_mh #(
    parameter int          NHARTS     = 1,
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter int          TICK_DIV   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    input  logic [31:0]       awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic [NHARTS-1:0] mtip,
    output logic [NHARTS-1:0] msip
);

    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RD_RESP, WR_DATA, WR_RESP} state_t;

    typedef enum logic [2:0] {R_MSIP, R_CMP_LO, R_CMP_HI, R_TIME_LO, R_TIME_HI, R_BAD} reg_kind_t;

    typedef struct packed {
        reg_kind_t  kind;
        logic [2:0] hart;
    } dec_t;

    // Map a bus address onto a register class and hart index; anything unmapped,
    // misaligned or beyond the implemented harts decodes as R_BAD.
    function automatic dec_t decode(input logic [31:0] addr);
        logic [31:0] off;
        dec_t        d;
        off    = addr - CLINT_BASE;
        d.kind = R_BAD;
        d.hart = 3'd0;
        if (off[31:16] == 16'h0000 && off[1:0] == 2'b00) begin
            if (off[15:0] < 16'(4 * NHARTS)) begin
                d.kind = R_MSIP;
                d.hart = off[4:2];
            end else if (off[15:0] >= 16'h4000 && off[15:0] < 16'(32'h4000 + 8 * NHARTS)) begin
                d.kind = off[2] ? R_CMP_HI : R_CMP_LO;
                d.hart = off[5:3];
            end else if (off[15:0] == 16'hBFF8) begin
                d.kind = R_TIME_LO;
            end else if (off[15:0] == 16'hBFFC) begin
                d.kind = R_TIME_HI;
            end
        end
        return d;
    endfunction

    // Byte-lane merge: lanes with a strobe take the new data, others keep the old.
    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] m;
        m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old_w & ~m) | (new_w & m);
    endfunction

    state_t            state;
    state_t            state_next;
    logic [31:0]       aw_addr_q;
    logic [PW-1:0]     prescaler;
    logic [63:0]       mtime;
    logic [63:0]       mtimecmp [NHARTS];
    logic [NHARTS-1:0] mtip_q;
    logic              tick;
    logic              ar_fire;
    logic              aw_fire;
    logic              w_fire;
    dec_t              rd_dec;
    dec_t              wr_dec;
    logic [63:0]       cmp_sel;
    logic              msip_bit;
    logic [31:0]       rd_word;
    logic              rd_err;
`ifdef CLINT_MSIP_EN
    logic [NHARTS-1:0] msip_q;
`endif

    assign rd_dec  = decode(araddr);
    assign wr_dec  = decode(aw_addr_q);
    assign tick    = (prescaler == PRE_MAX);
    assign ar_fire = (state == IDLE) && arvalid;
    assign aw_fire = (state == IDLE) && !arvalid && awvalid;
    assign w_fire  = (state == WR_DATA) && wvalid;
    assign mtip    = mtip_q;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and handshake outputs; a read wins a same-cycle tie with a write
    always_comb begin
        state_next = state;
        arready    = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        rvalid     = 1'b0;
        bvalid     = 1'b0;
        case (state)
            IDLE: begin
                arready = 1'b1;
                awready = !arvalid;
                if (arvalid) begin
                    state_next = RD_RESP;
                end else if (awvalid) begin
                    state_next = WR_DATA;
                end
            end
            RD_RESP: begin
                rvalid = 1'b1;
                if (rready) begin
                    state_next = IDLE;
                end
            end
            WR_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Read data mux for the address presented on the AR channel
    always_comb begin
        cmp_sel  = 64'd0;
        msip_bit = 1'b0;
        rd_word  = 32'd0;
        rd_err   = 1'b0;
        for (int h = 0; h < NHARTS; h++) begin
            if (rd_dec.hart == 3'(h)) begin
                cmp_sel = mtimecmp[h];
`ifdef CLINT_MSIP_EN
                msip_bit = msip_q[h];
`endif
            end
        end
        case (rd_dec.kind)
            R_MSIP:    rd_word = {31'd0, msip_bit};
            R_CMP_LO:  rd_word = cmp_sel[31:0];
            R_CMP_HI:  rd_word = cmp_sel[63:32];
            R_TIME_LO: rd_word = mtime[31:0];
            R_TIME_HI: rd_word = mtime[63:32];
            default:   rd_err  = 1'b1;
        endcase
    end

    // Response registers and latched write address; held until the response is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata     <= 32'd0;
            rresp     <= 2'b00;
            bresp     <= 2'b00;
            aw_addr_q <= 32'd0;
        end else begin
            if (ar_fire) begin
                rdata <= rd_word;
                rresp <= rd_err ? 2'b10 : 2'b00;
            end
            if (aw_fire) begin
                aw_addr_q <= awaddr;
            end
            if (w_fire) begin
                bresp <= (wr_dec.kind == R_BAD) ? 2'b10 : 2'b00;
            end
        end
    end

    // Prescaler and mtime; a software write to mtime replaces that cycle's increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            mtime     <= 64'd0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (w_fire && wr_dec.kind == R_TIME_LO) begin
                mtime[31:0] <= merge(mtime[31:0], wdata, wstrb);
            end else if (w_fire && wr_dec.kind == R_TIME_HI) begin
                mtime[63:32] <= merge(mtime[63:32], wdata, wstrb);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

    // Per-hart compare registers, reset to all-ones so no timer interrupt fires at boot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int h = 0; h < NHARTS; h++) begin
                mtimecmp[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
            end
        end else begin
            for (int h = 0; h < NHARTS; h++) begin
                if (w_fire && wr_dec.hart == 3'(h)) begin
                    if (wr_dec.kind == R_CMP_LO) begin
                        mtimecmp[h][31:0] <= merge(mtimecmp[h][31:0], wdata, wstrb);
                    end else if (wr_dec.kind == R_CMP_HI) begin
                        mtimecmp[h][63:32] <= merge(mtimecmp[h][63:32], wdata, wstrb);
                    end
                end
            end
        end
    end

    // Registered timer interrupt: one cycle behind the unsigned compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtip_q <= '0;
        end else begin
            for (int h = 0; h < NHARTS; h++) begin
                mtip_q[h] <= (mtime >= mtimecmp[h]);
            end
        end
    end

`ifdef CLINT_MSIP_EN
    // Software interrupt bits; only bit 0 of lane 0 is meaningful
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msip_q <= '0;
        end else begin
            for (int h = 0; h < NHARTS; h++) begin
                if (w_fire && wr_dec.kind == R_MSIP && wr_dec.hart == 3'(h) && wstrb[0]) begin
                    msip_q[h] <= wdata[0];
                end
            end
        end
    end

    assign msip = msip_q;
`else
    assign msip = '0;
`endif

endmodule

// File: tb/tb_ysyx_25020037_clint_mh.sv
// tb/tb_ysyx_25020037_clint_mh.sv - directed bench for the CLINT, TICK_DIV=1 and TICK_DIV=4 instances on one bus
module tb_ysyx_25020037_clint_mh;

    localparam logic [31:0] B = 32'h0200_0000;
`ifdef CLINT_MSIP_EN
    localparam logic [1:0]  MSIP_EXP = 2'b10;
    localparam logic [31:0] MSIP_RD  = 32'd1;
`else
    localparam logic [1:0]  MSIP_EXP = 2'b00;
    localparam logic [31:0] MSIP_RD  = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic [3:0]  wstrb = '0;

    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp, mtip, msip;
    logic        arready4, rvalid4, awready4, wready4, bvalid4;
    logic [31:0] rdata4;
    logic [1:0]  rresp4, bresp4, mtip4, msip4;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] d, d4;
    logic [1:0]  r;

    always #5 clk = ~clk;

    ysyx_25020037_clint_mh #(.NHARTS(2), .CLINT_BASE(B), .TICK_DIV(1)) u_dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .mtip(mtip), .msip(msip)
    );

    ysyx_25020037_clint_mh #(.NHARTS(2), .CLINT_BASE(B), .TICK_DIV(4)) u_div4 (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready4),
        .rdata(rdata4), .rresp(rresp4), .rvalid(rvalid4), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready4),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready4),
        .bresp(bresp4), .bvalid(bvalid4), .bready(bready),
        .mtip(mtip4), .msip(msip4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] dat, output logic [1:0] resp,
                      output logic [31:0] dat4);
        int n;
        n       = 0;
        araddr  = a;
        arvalid = 1'b1;
        while (arready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rd_arready", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("rd_rvalid", {rvalid, rvalid4}, 2'b11);
        dat    = rdata;
        resp   = rresp;
        dat4   = rdata4;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        chk("rd_rvalid_drop", rvalid, 0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                      output logic [1:0] resp);
        int n;
        n       = 0;
        awaddr  = a;
        awvalid = 1'b1;
        while (awready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wr_awready", awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wdata   = dat;
        wstrb   = s;
        wvalid  = 1'b1;
        chk("wr_wready", {wready, wready4}, 2'b11);
        @(posedge clk); #1;
        wvalid = 1'b0;
        chk("wr_bvalid", {bvalid, bvalid4}, 2'b11);
        resp   = bresp;
        chk("wr_bresp4", bresp4, bresp);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {arready, awready, wready, arready4, awready4, wready4}, 6'b110110);
        chk("rst_valid", {rvalid, bvalid, rvalid4, bvalid4}, 4'b0000);
        chk("rst_resp", {rresp, bresp, rresp4, bresp4}, 8'h00);
        chk("rst_rdata", {rdata, rdata4}, 64'h0);
        chk("rst_irq", {mtip, msip, mtip4, msip4}, 8'h00);
        rst = 1'b0;

        // free-running mtime, prescaled copy advances at a quarter rate
        repeat (10) @(posedge clk);
        #1;
        rd(B + 32'hBFF8, d, r, d4);
        chk("t1_mtime_range", (d >= 32'd9 && d <= 32'd11), 1);
        chk("t1_rresp", r, 2'b00);
        chk("t1_div4", d4, d / 4);

        // mtimecmp[0] = 0x20, then set mtime to 0x10 and count to the match
        wr(B + 32'h4000, 32'h0000_0020, 4'hF, r);
        chk("t2_bresp_lo", r, 2'b00);
        wr(B + 32'h4004, 32'h0000_0000, 4'hF, r);
        chk("t2_bresp_hi", r, 2'b00);
        chk("t2_mtip_before", mtip, 2'b00);
        wr(B + 32'hBFF8, 32'h0000_0010, 4'hF, r);
        repeat (15) @(posedge clk);
        #1;
        chk("t2_mtip_at_match", mtip, 2'b00);
        @(posedge clk); #1;
        chk("t2_mtip_rise", mtip, 2'b01);
        wr(B + 32'h4000, 32'hFFFF_FFFF, 4'hF, r);
        chk("t2_mtip_fall", mtip, 2'b00);

        // carry from mtime lo into hi
        wr(B + 32'hBFFC, 32'h0000_0000, 4'hF, r);
        wr(B + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, r);
        rd(B + 32'hBFFC, d, r, d4);
        chk("t3_mtime_hi", d, 32'd1);
        rd(B + 32'hBFF8, d, r, d4);
        chk("t3_mtime_lo", d, 32'd2);
        chk("t3_mtip_cmp_passed", mtip, 2'b01);

        // msip, error decode and byte strobes
        wr(B + 32'h0004, 32'h0000_0001, 4'hF, r);
        chk("t4_msip_bresp", r, 2'b00);
        chk("t4_msip_out", msip, MSIP_EXP);
        rd(B + 32'h0004, d, r, d4);
        chk("t4_msip_rd", {r, d}, {2'b00, MSIP_RD});
        rd(B + 32'h0008, d, r, d4);
        chk("t4_msip_oob_rd", {r, d}, {2'b10, 32'h0});
        wr(B + 32'h0008, 32'h0000_0001, 4'hF, r);
        chk("t4_msip_oob_wr", r, 2'b10);
        rd(B + 32'h1000, d, r, d4);
        chk("t4_hole_rd", {r, d}, {2'b10, 32'h0});
        rd(B + 32'h0001_0000, d, r, d4);
        chk("t4_window_rd", {r, d}, {2'b10, 32'h0});
        rd(B + 32'h4010, d, r, d4);
        chk("t4_cmp_oob_rd", {r, d}, {2'b10, 32'h0});
        wr(B + 32'h4008, 32'h1234_5678, 4'b0011, r);
        chk("t4_strb_bresp", r, 2'b00);
        rd(B + 32'h4008, d, r, d4);
        chk("t4_strb_rd", {r, d}, {2'b00, 32'hFFFF_5678});
        rd(B + 32'h400C, d, r, d4);
        chk("t4_cmp1_hi", d, 32'hFFFF_FFFF);

        // simultaneous AR and AW: read first, then the write; stalled R channel stays stable
        araddr  = B + 32'h4008;
        arvalid = 1'b1;
        awaddr  = B + 32'h4004;
        awvalid = 1'b1;
        #1;
        chk("t5_tie_ready", {arready, awready}, 2'b10);
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("t5_rvalid", rvalid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t5_stall", {rvalid, awready, rresp, rdata}, {1'b1, 1'b0, 2'b00, 32'hFFFF_5678});
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        chk("t5_aw_after_rd", {rvalid, awready}, 2'b01);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wdata   = 32'h0000_0001;
        wstrb   = 4'hF;
        wvalid  = 1'b1;
        chk("t5_wready", wready, 1);
        @(posedge clk); #1;
        wvalid = 1'b0;
        chk("t5_bresp", {bvalid, bresp}, 3'b100);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        chk("t5_mtip_cleared", mtip, 2'b00);
        rd(B + 32'h4004, d, r, d4);
        chk("t5_cmp0_hi", {r, d}, {2'b00, 32'h1});

        // reset in WR_DATA: transaction abandoned, registers back to reset values
        awaddr  = B + 32'h4000;
        awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        chk("t6_in_wr_data", wready, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_async_idle", {arready, awready, wready, bvalid}, 4'b1100);
        @(posedge clk); #1;
        rst    = 1'b0;
        wdata  = 32'h0000_0000;
        wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t6_no_bvalid", {bvalid, bvalid4, wready}, 3'b000);
        end
        wvalid = 1'b0;
        rd(B + 32'hBFF8, d, r, d4);
        chk("t6_mtime_lo", d, 32'd3);
        chk("t6_div4_lo", d4, 32'd0);
        rd(B + 32'hBFFC, d, r, d4);
        chk("t6_mtime_hi", {d, d4}, 64'h0);
        rd(B + 32'h4000, d, r, d4);
        chk("t6_cmp0_lo", {d, d4}, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(B + 32'h4004, d, r, d4);
        chk("t6_cmp0_hi", {d, d4}, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(B + 32'hBFF8, d, r, d4);
        chk("t6_mtime_lo2", d, 32'd11);
        chk("t6_div4_lo2", d4, 32'd2);
        chk("t6_irq", {mtip, msip, mtip4, msip4}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
